gray_seq_ctrl: RTL and testbench
================================

# gray_seq_ctrl

Command-driven sequencer for the Gray-code counter. Accepts a burst request of N steps over a valid/ready handshake, drives the counter's enable for exactly N steps, supports pause and abort, and reports completion. It sits between a control master (CSR or test sequencer) and a `gray_cnt` instance, giving callers bounded Gray-code sweeps instead of a free-running enable.

## Interface

- `WIDTH`, default 4: Gray code width; passed to `gray_cnt`.
- `LEN_W`, default 8: width of the step-count field.

- `clk`, input, 1: the single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset; also resets the counter instance.
- `cmd_valid`, input, 1: a command is offered.
- `cmd_ready`, output, 1: the block can accept a command; high only in IDLE.
- `cmd_len`, input, LEN_W: number of Gray steps to issue; sampled on accept.
- `cmd_abort`, input, 1: terminate the current burst early.
- `pause`, input, 1: hold stepping while high.
- `busy`, output, 1: state is RUN or HOLD.
- `gray`, output, WIDTH: current Gray value, from the counter instance.
- `gray_valid`, output, 1: `gray` changed at the last edge (one per step).
- `wrap`, output, 1: `gray` returned to all-zero at the last edge.
- `done`, output, 1: one-cycle burst-completion pulse.
- `aborted`, output, 1: qualifies `done`; high when the burst ended by abort.

## Operation

- **States:** IDLE, RUN, HOLD, DONE.
- **IDLE:** `cmd_ready`=1. On `cmd_valid` with `cmd_len`≠0, load `remaining`=`cmd_len` and go to RUN. On `cmd_valid` with `cmd_len`=0, go to DONE with no steps and `aborted`=0.
- **RUN:** `step` = !`cmd_abort` && !`pause`.
  - On `step`: pulse the counter enable and decrement `remaining`. When `remaining`==1, go to DONE.
  - `cmd_abort`: no step; go to DONE with `aborted`=1. Abort beats pause.
  - `pause` without abort: no step; go to HOLD.
- **HOLD:**
  - `cmd_abort`: go to DONE, `aborted`=1.
  - `pause` low: return to RUN with no step in that cycle. Stepping resumes the next cycle.
- **DONE:** lasts one cycle, then IDLE. `cmd_ready`=0. `cmd_abort` and `pause` are ignored.
- **Counter position:** the counter is never cleared by a command. Each burst continues from the current Gray position. Only `rst_n` returns it to 0.
- **`remaining` width:** LEN_W bits, unsigned; it never underflows.
- **Counter enable:** equals `step` in RUN and is 0 in every other state.

## Timing

- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `gray`=0, `gray_valid`=0, `wrap`=0, `done`=0, `aborted`=0, `remaining`=0.
- **Accept:** `cmd_valid` && `cmd_ready` is sampled at edge E0. RUN holds in the cycle after E0, and the first enable occurs in that cycle.
- **Step output:** the enable sampled at edge Ek updates `gray` at Ek. `gray_valid` and `wrap` are registered at the same edge, so they are coincident with the new value.
- **Unpaused burst, `cmd_len`=L:**
  - `gray_valid` is high for L consecutive cycles, after edges E1..EL.
  - `done` is high in the cycle after EL, the same cycle as the last `gray_valid`.
  - IDLE and `cmd_ready`=1 follow after E(L+1). Command-to-command throughput is L+2 cycles.
- **Zero-length command:** `done` is high in the cycle after E0; `cmd_ready` returns one cycle later.
- **Pause latency:** `pause` takes effect in the cycle it is high, so no step occurs that cycle. After release, the first step follows one cycle later (HOLD→RUN).
- **Abort latency:** `done`/`aborted` are high one cycle after `cmd_abort` is sampled. No step occurs in the abort cycle.
- **`wrap`:** asserted with the step whose new `gray` is 0. For WIDTH=4 that is every 16th step after reset.
- **Reset mid-burst:** everything returns to reset values immediately. No `done` pulse is produced, and the burst is lost.

## Structure

- **Package `gray_seq_pkg`:** state enum IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
- **Sub-module:** one `gray_cnt` instance.
  - Its `enable` is driven by `step`.
  - `clk`/`rst_n` are shared with the controller.
  - Its `gray` output feeds the `gray` port directly.
- **`wrap` logic:** registered (`step` && next Gray==0). Either derive the next value locally, or register `step` and compare the counter output one cycle later. Either way, `wrap` must stay aligned with `gray_valid`.

## Test plan

- **Basic burst:** reset, then `cmd_len`=5, no pause.
  - Required: `gray` takes 1,3,2,6,7 on 5 consecutive `gray_valid` cycles.
  - Required: `done`=1, `aborted`=0 with the 7; `cmd_ready` returns two cycles after the last accept edge +5.
- **Pause:** `cmd_len`=4, `pause` high for 3 cycles after the 2nd step.
  - Required: exactly 4 `gray_valid` pulses with a 4-cycle gap; `gray` ends at 6.
- **Abort:** `cmd_len`=10, `cmd_abort` pulsed after the 3rd step.
  - Required: `gray`=2 is final; `done`=`aborted`=1 next cycle; no further `gray_valid`.
- **Zero length and ignored command:** `cmd_len`=0.
  - Required: `done` after one cycle with no `gray_valid`, and `gray` unchanged.
  - Required: a `cmd_valid` held during DONE is accepted only once IDLE is reached.
- **Wrap and continuation:** two bursts of `cmd_len`=10 and `cmd_len`=8, WIDTH=4.
  - Required: the second burst resumes from `gray`=15 (the 10th step).
  - Required: `wrap` pulses exactly once, on its 6th step (`gray`=0).
- **Reset mid-burst:** `rst_n` low during RUN.
  - Required: all outputs at reset values within the reset; no `done` pulse.
  - Required: the next burst starts from `gray`=1.

Source files
------------

// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared types for the Gray-code burst sequencer
package gray_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// rtl/gray_seq_ctrl_if.sv - command and status bundle between a control master and the sequencer
interface gray_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_abort;
    logic             pause;
    logic             busy;
    logic [WIDTH-1:0] gray;
    logic             gray_valid;
    logic             wrap;
    logic             done;
    logic             aborted;

    modport master (
        output cmd_valid, cmd_len, cmd_abort, pause,
        input  cmd_ready, busy, gray, gray_valid, wrap, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_abort, pause,
        output cmd_ready, busy, gray, gray_valid, wrap, done, aborted
    );
endinterface

// File: rtl/gray_cnt.sv
// rtl/gray_cnt.sv - enable-gated Gray-code counter built on a binary register
module gray_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] gray
);
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;

    always_comb begin
        bin_d = enable ? bin_q + WIDTH'(1) : bin_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
        end else begin
            bin_q <= bin_d;
        end
    end

    assign gray = bin_q ^ (bin_q >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - runs bounded Gray-code sweeps of cmd_len steps with pause and abort
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gray_seq_ctrl_if.slave   bus
);
    // Gray code of the all-ones binary value: the position just before wrap.
    localparam logic [WIDTH-1:0] LAST_GRAY = WIDTH'(1) << (WIDTH - 1);

    seq_state_e       state_q;
    logic [LEN_W-1:0] remaining_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             gray_valid_q;
    logic             wrap_q;
    logic             done_q;
    logic             aborted_q;
    logic             step;

    assign step = (state_q == ST_RUN) && !bus.cmd_abort && !bus.pause;

    gray_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (step),
        .gray   (bus.gray)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            gray_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            gray_valid_q <= step;
            wrap_q       <= step && (bus.gray == LAST_GRAY);
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            remaining_q <= bus.cmd_len;
                            state_q     <= ST_RUN;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over pause.
                    if (bus.cmd_abort) begin
                        remaining_q <= '0;
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        aborted_q   <= 1'b1;
                    end else if (bus.pause) begin
                        state_q <= ST_HOLD;
                    end else begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.cmd_abort) begin
                        remaining_q <= '0;
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        aborted_q   <= 1'b1;
                    end else if (!bus.pause) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.gray_valid = gray_valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - self-checking bench for gray_seq_ctrl
module tb_gray_seq_ctrl;
    localparam int WIDTH  = 4;
    localparam int LEN_W  = 8;
    localparam int MAXOBS = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pos    = 0;

    logic             tr_gv   [MAXOBS];
    logic             tr_wrap [MAXOBS];
    logic             tr_done [MAXOBS];
    logic             tr_ab   [MAXOBS];
    logic [WIDTH-1:0] tr_gray [MAXOBS];
    int               tr_len;
    int               done_idx;

    logic             ex_gv   [MAXOBS];
    logic             ex_wrap [MAXOBS];
    logic [WIDTH-1:0] ex_gray [MAXOBS];
    int               ex_done_idx;
    logic             ex_aborted;
    int               ex_end_pos;

    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    gray_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [WIDTH-1:0] gray_of(input int n);
        logic [WIDTH-1:0] b;
        b = WIDTH'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_abort = 1'b0;
        bus.pause     = 1'b0;
        rst_n         = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pos = 0;
    endtask

    // Issues one command and records every cycle from the accept edge until done.
    task automatic drive_burst(input int len, input int ps, input int pl, input int ab);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        tick();
        bus.cmd_valid = 1'b0;
        done_idx = -1;
        tr_len   = 0;
        for (int c = 0; c < MAXOBS; c++) begin
            tr_gv[c]   = bus.gray_valid;
            tr_wrap[c] = bus.wrap;
            tr_done[c] = bus.done;
            tr_ab[c]   = bus.aborted;
            tr_gray[c] = bus.gray;
            tr_len     = c + 1;
            if (bus.done) begin
                done_idx = c;
                break;
            end
            bus.pause     = (c >= ps) && (c < ps + pl);
            bus.cmd_abort = (c == ab);
            tick();
        end
        bus.pause     = 1'b0;
        bus.cmd_abort = 1'b0;
    endtask

    // Expected trace: step j of an unpaused burst lands j cycles after accept;
    // a pause of pl cycles starting before step ps+1 delays later steps by pl+1.
    task automatic build_model(input int len, input int ps, input int pl, input int ab, input int start);
        int p;
        for (int i = 0; i < MAXOBS; i++) begin
            ex_gv[i]   = 1'b0;
            ex_wrap[i] = 1'b0;
            ex_gray[i] = '0;
        end
        ex_aborted = 1'b0;
        if (len == 0) begin
            ex_done_idx = 0;
        end else if (ab >= 0 && ab < len) begin
            for (int j = 1; j <= ab; j++) ex_gv[j] = 1'b1;
            ex_done_idx = ab + 1;
            ex_aborted  = 1'b1;
        end else begin
            for (int j = 1; j <= len; j++) begin
                int o;
                o = j + ((pl > 0 && j > ps) ? pl + 1 : 0);
                ex_gv[o]    = 1'b1;
                ex_done_idx = o;
            end
        end
        p = start;
        for (int o = 0; o <= ex_done_idx; o++) begin
            if (ex_gv[o]) p++;
            ex_gray[o] = gray_of(p);
            ex_wrap[o] = ex_gv[o] && ((p % (1 << WIDTH)) == 0);
        end
        ex_end_pos = p;
    endtask

    task automatic test_reset();
        logic [WIDTH+5:0] exp_v;
        apply_reset();
        exp_v = {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000};
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.gray, bus.gray_valid, bus.wrap, bus.done, bus.aborted} !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got %b required %b",
                {bus.cmd_ready, bus.busy, bus.gray, bus.gray_valid, bus.wrap, bus.done, bus.aborted}, exp_v);
        end
    endtask

    task automatic test_basic_burst();
        logic [WIDTH-1:0] seq [5];
        seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7};
        apply_reset();
        drive_burst(5, 0, 0, -1);
        checks++;
        if (done_idx !== 5) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d required 5", done_idx);
        end
        checks++;
        if (tr_gv[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_step_at_accept: got %b required 0", tr_gv[0]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k + 1 >= tr_len || tr_gv[k+1] !== 1'b1 || tr_gray[k+1] !== seq[k]) begin
                errors++;
                $display("FAIL basic_step%0d: got gv=%b gray=%0d required gv=1 gray=%0d",
                    k + 1, tr_gv[k+1], tr_gray[k+1], seq[k]);
            end
        end
        checks++;
        if (tr_ab[5] !== 1'b0) begin
            errors++;
            $display("FAIL basic_aborted: got %b required 0", tr_ab[5]);
        end
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_return: got ready=%b busy=%b required ready=1 busy=0", bus.cmd_ready, bus.busy);
        end
        pos = 5;
    endtask

    task automatic test_pause();
        int cnt;
        apply_reset();
        drive_burst(4, 2, 3, -1);
        cnt = 0;
        for (int o = 0; o < tr_len; o++) if (tr_gv[o]) cnt++;
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("FAIL pause_step_count: got %0d required 4", cnt);
        end
        checks++;
        if ({tr_gv[1], tr_gv[2], tr_gv[3], tr_gv[4], tr_gv[5], tr_gv[6], tr_gv[7], tr_gv[8]} !== 8'b11000011) begin
            errors++;
            $display("FAIL pause_gap: got %b required 11000011",
                {tr_gv[1], tr_gv[2], tr_gv[3], tr_gv[4], tr_gv[5], tr_gv[6], tr_gv[7], tr_gv[8]});
        end
        checks++;
        if (done_idx !== 8 || tr_gray[8] !== 4'd6) begin
            errors++;
            $display("FAIL pause_final: got done_idx=%0d gray=%0d required 8 and 6", done_idx, tr_gray[8]);
        end
        tick();
        pos = 4;
    endtask

    task automatic test_abort();
        int extra;
        apply_reset();
        drive_burst(10, 0, 0, 3);
        checks++;
        if (done_idx !== 4 || tr_ab[4] !== 1'b1 || tr_gray[4] !== 4'd2 || tr_gv[4] !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: got done_idx=%0d aborted=%b gray=%0d gv=%b required 4 1 2 0",
                done_idx, tr_ab[4], tr_gray[4], tr_gv[4]);
        end
        extra = 0;
        repeat (5) begin
            tick();
            if (bus.gray_valid) extra++;
        end
        checks++;
        if (extra !== 0 || bus.gray !== 4'd2) begin
            errors++;
            $display("FAIL abort_quiet: got extra_steps=%0d gray=%0d required 0 and 2", extra, bus.gray);
        end
        pos = 3;
    endtask

    task automatic test_zero_len();
        int cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = '0;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.aborted !== 1'b0 || bus.gray_valid !== 1'b0 ||
            bus.gray !== gray_of(pos) || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b ab=%b gv=%b gray=%0d ready=%b required 1 0 0 %0d 0",
                bus.done, bus.aborted, bus.gray_valid, bus.gray, bus.cmd_ready, gray_of(pos));
        end
        bus.cmd_len = LEN_W'(3);
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL held_cmd_in_done: got ready=%b busy=%b done=%b required 1 0 0",
                bus.cmd_ready, bus.busy, bus.done);
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_cmd_accept: got busy=%b ready=%b required 1 0", bus.busy, bus.cmd_ready);
        end
        cnt = 0;
        repeat (6) begin
            tick();
            if (bus.gray_valid) cnt++;
        end
        pos = pos + 3;
        checks++;
        if (cnt !== 3 || bus.gray !== gray_of(pos) || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_cmd_burst: got steps=%0d gray=%0d ready=%b required 3 %0d 1",
                cnt, bus.gray, bus.cmd_ready, gray_of(pos));
        end
    endtask

    task automatic test_wrap_continuation();
        int wraps;
        apply_reset();
        drive_burst(10, 0, 0, -1);
        wraps = 0;
        for (int o = 0; o < tr_len; o++) if (tr_wrap[o]) wraps++;
        checks++;
        if (done_idx !== 10 || tr_gray[10] !== 4'd15 || wraps !== 0) begin
            errors++;
            $display("FAIL wrap_first_burst: got done_idx=%0d gray=%0d wraps=%0d required 10 15 0",
                done_idx, tr_gray[10], wraps);
        end
        tick();
        drive_burst(8, 0, 0, -1);
        checks++;
        if (tr_gray[0] !== 4'd15) begin
            errors++;
            $display("FAIL wrap_resume: got %0d required 15", tr_gray[0]);
        end
        wraps = 0;
        for (int o = 0; o < tr_len; o++) if (tr_wrap[o]) wraps++;
        checks++;
        if (wraps !== 1 || tr_wrap[6] !== 1'b1 || tr_gray[6] !== 4'd0 || tr_gv[6] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse: got wraps=%0d wrap6=%b gray6=%0d gv6=%b required 1 1 0 1",
                wraps, tr_wrap[6], tr_gray[6], tr_gv[6]);
        end
        tick();
        pos = 18;
    endtask

    task automatic test_reset_mid_burst();
        logic [WIDTH+5:0] exp_v;
        int dones;
        apply_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(20);
        tick();
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        exp_v = {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000};
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.gray, bus.gray_valid, bus.wrap, bus.done, bus.aborted} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_burst: got %b required %b",
                {bus.cmd_ready, bus.busy, bus.gray, bus.gray_valid, bus.wrap, bus.done, bus.aborted}, exp_v);
        end
        dones = 0;
        repeat (3) begin
            tick();
            if (bus.done) dones++;
        end
        rst_n = 1'b1;
        tick();
        if (bus.done) dones++;
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses required 0", dones);
        end
        pos = 0;
        drive_burst(2, 0, 0, -1);
        checks++;
        if (tr_gray[1] !== 4'd1 || tr_gv[1] !== 1'b1 || done_idx !== 2) begin
            errors++;
            $display("FAIL reset_restart: got gray=%0d gv=%b done_idx=%0d required 1 1 2",
                tr_gray[1], tr_gv[1], done_idx);
        end
        tick();
        pos = 2;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int len, mode, ps, pl, ab;
            len  = int'($urandom_range(0, 20));
            mode = int'($urandom_range(0, 2));
            ps = 0; pl = 0; ab = -1;
            if (len > 0 && mode == 1) begin
                ps = int'($urandom_range(0, len - 1));
                pl = int'($urandom_range(1, 4));
            end else if (len > 0 && mode == 2) begin
                ab = int'($urandom_range(0, len - 1));
            end
            build_model(len, ps, pl, ab, pos);
            drive_burst(len, ps, pl, ab);
            checks++;
            if (done_idx !== ex_done_idx) begin
                errors++;
                $display("FAIL rnd%0d_done_cycle: got %0d required %0d (len=%0d ps=%0d pl=%0d ab=%0d)",
                    it, done_idx, ex_done_idx, len, ps, pl, ab);
            end
            for (int o = 0; o < tr_len; o++) begin
                checks++;
                if ({tr_gv[o], tr_gray[o], tr_wrap[o], tr_done[o]} !==
                    {ex_gv[o], ex_gray[o], ex_wrap[o], (o == ex_done_idx)}) begin
                    errors++;
                    $display("FAIL rnd%0d_obs%0d: got gv=%b gray=%0d wrap=%b done=%b required gv=%b gray=%0d wrap=%b done=%b",
                        it, o, tr_gv[o], tr_gray[o], tr_wrap[o], tr_done[o],
                        ex_gv[o], ex_gray[o], ex_wrap[o], (o == ex_done_idx));
                end
            end
            if (done_idx >= 0) begin
                checks++;
                if (tr_ab[done_idx] !== ex_aborted) begin
                    errors++;
                    $display("FAIL rnd%0d_aborted: got %b required %b", it, tr_ab[done_idx], ex_aborted);
                end
            end
            pos = ex_end_pos;
            tick();
            checks++;
            if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_idle: got ready=%b busy=%b required 1 0", it, bus.cmd_ready, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_pause();
        test_abort();
        test_zero_len();
        test_wrap_continuation();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
